// File: rtl/i2s_pkg.sv
// Shared defaults, state encoding and channel constants for the I2S capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2s_pkg;

    localparam int I2S_SAMPLE_W  = 18;
    localparam int I2S_FRAME_LEN = 576;
    localparam int I2S_ADDR_W    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } rx_state_t;

    // Word-select level of each channel slot.
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the external I2S master's bclk/ws/din into the clk domain and flags bclk rising edges.
// Latency: pin edge -> bclk_rise after 2 synchronizer stages plus the edge register.
// Backpressure: none; the master cannot be stalled.
//
// Ports: clk, rst_n (async active-low); i2s_bclk/i2s_ws/i2s_din raw pins;
//        bclk_rise one-cycle edge flag, ws_s/din_s synchronized levels aligned with it.
module i2s_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i2s_bclk,
    input  logic i2s_ws,
    input  logic i2s_din,
    output logic bclk_rise,
    output logic ws_s,
    output logic din_s
);

    logic bclk_meta;
    logic bclk_sync;
    logic bclk_prev;
    logic ws_meta;
    logic din_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_prev <= 1'b0;
            ws_meta   <= 1'b0;
            ws_s      <= 1'b0;
            din_meta  <= 1'b0;
            din_s     <= 1'b0;
        end else begin
            bclk_meta <= i2s_bclk;
            bclk_sync <= bclk_meta;
            bclk_prev <= bclk_sync;
            ws_meta   <= i2s_ws;
            ws_s      <= ws_meta;
            din_meta  <= i2s_din;
            din_s     <= din_meta;
        end
    end

    // ws/din share the bclk synchronizer depth, so they are sampled at the same point.
    assign bclk_rise = bclk_sync & ~bclk_prev;

endmodule

// File: rtl/i2s_rx_stage.sv
// I2S receiver: deserializes left/right words and writes stereo pairs into a PCM buffer.
// Latency: write strobe 1 clk after the edge-detect cycle that finalizes the right word.
// Backpressure: consumer holds the buffer until frame_done; pairs arriving meanwhile are dropped.
//
// Ports: clk, rst_n (async active-low), enable (capture level);
//        i2s_bclk/i2s_ws/i2s_din from the external master;
//        pcm_write_enable/addr/data_ch0/data_ch1 buffer write port;
//        frame_ready (out pulse) / frame_done (in pulse) buffer handoff;
//        overrun_count saturating dropped-pair count.
// Optional: define I2S_RX_OVERRUN_CNT_EN to build the overrun counter; otherwise it reads 0.
module i2s_rx_stage
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W  = I2S_SAMPLE_W,
    parameter int FRAME_LEN = I2S_FRAME_LEN,
    parameter int ADDR_W    = I2S_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                i2s_bclk,
    input  logic                i2s_ws,
    input  logic                i2s_din,
    output logic                pcm_write_enable,
    output logic [ADDR_W-1:0]   pcm_write_addr,
    output logic [SAMPLE_W-1:0] pcm_write_data_ch0,
    output logic [SAMPLE_W-1:0] pcm_write_data_ch1,
    output logic                frame_ready,
    input  logic                frame_done,
    output logic [7:0]          overrun_count
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    // Bit counter saturates here; any position at or past it is outside the kept word.
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0]  MSB_POS   = CNT_W'(SAMPLE_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic bclk_rise;
    logic ws_s;
    logic din_s;

    i2s_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2s_bclk  (i2s_bclk),
        .i2s_ws    (i2s_ws),
        .i2s_din   (i2s_din),
        .bclk_rise (bclk_rise),
        .ws_s      (ws_s),
        .din_s     (din_s)
    );

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic                ws_prev;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] cur_word;
    logic [SAMPLE_W-1:0] fin_word;
    logic                slot_change;
    logic                left_fin;
    logic                right_fin;

    always_comb begin
        fin_word = cur_word;
        if (bit_cnt < CNT_MAX) begin
            fin_word = cur_word | (SAMPLE_W'(din_s) << (MSB_POS - bit_cnt));
        end
        // One-bit delay framing: the edge where ws flips still carries the old slot's LSB.
        slot_change = bclk_rise && (ws_s != ws_prev);
        left_fin    = slot_change && (ws_prev == LEFT);
        right_fin   = slot_change && (ws_prev == RIGHT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_prev  <= 1'b0;
            bit_cnt  <= '0;
            cur_word <= '0;
        end else if (bclk_rise) begin
            ws_prev <= ws_s;
            if (ws_s != ws_prev) begin
                bit_cnt  <= '0;
                cur_word <= '0;
            end else begin
                cur_word <= fin_word;
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture state machine and buffer write port
    // ------------------------------------------------------------------
    rx_state_t           state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] left_hold;
    logic                left_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            wr_addr            <= '0;
            left_hold          <= '0;
            left_vld           <= 1'b0;
            pcm_write_enable   <= 1'b0;
            pcm_write_addr     <= '0;
            pcm_write_data_ch0 <= '0;
            pcm_write_data_ch1 <= '0;
            frame_ready        <= 1'b0;
        end else begin
            pcm_write_enable <= 1'b0;
            frame_ready      <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                wr_addr  <= '0;
                left_vld <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A right slot ending means a left slot starts next: aligned.
                        if (right_fin) begin
                            state    <= RUN;
                            left_vld <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (left_fin) begin
                            left_hold <= fin_word;
                            left_vld  <= 1'b1;
                        end else if (right_fin) begin
                            left_vld <= 1'b0;
                            if (left_vld) begin
                                pcm_write_enable   <= 1'b1;
                                pcm_write_addr     <= wr_addr;
                                pcm_write_data_ch0 <= left_hold;
                                pcm_write_data_ch1 <= fin_word;
                                if (wr_addr == LAST_ADDR) begin
                                    wr_addr     <= '0;
                                    frame_ready <= 1'b1;
                                    state       <= WAIT;
                                end else begin
                                    wr_addr <= wr_addr + 1'b1;
                                end
                            end
                        end
                    end
                    WAIT: begin
                        // Keep assembling so the pair after release is correctly aligned.
                        if (left_fin) begin
                            left_hold <= fin_word;
                            left_vld  <= 1'b1;
                        end else if (right_fin) begin
                            left_vld <= 1'b0;
                        end
                        if (frame_done) begin
                            state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 8'd0;
        end else if (enable && (state == WAIT) && right_fin && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign overrun_count = overrun_q;
`else
    assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_rx_stage.sv
// Directed bench for i2s_rx_stage: stimulus pushes expected writes, a monitor pops and compares.
// Latency: n/a.
// Backpressure: frame_done driven by the bench only where the sequence calls for it.
module tb_i2s_rx_stage;

    localparam int SW = 18;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          i2s_bclk = 1'b0;
    logic          i2s_ws = 1'b0;
    logic          i2s_din = 1'b0;
    logic          frame_done = 1'b0;
    logic          pcm_write_enable;
    logic [AW-1:0] pcm_write_addr;
    logic [SW-1:0] pcm_write_data_ch0;
    logic [SW-1:0] pcm_write_data_ch1;
    logic          frame_ready;
    logic [7:0]    overrun_count;

    i2s_rx_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .i2s_bclk           (i2s_bclk),
        .i2s_ws             (i2s_ws),
        .i2s_din            (i2s_din),
        .pcm_write_enable   (pcm_write_enable),
        .pcm_write_addr     (pcm_write_addr),
        .pcm_write_data_ch0 (pcm_write_data_ch0),
        .pcm_write_data_ch1 (pcm_write_data_ch1),
        .frame_ready        (frame_ready),
        .frame_done         (frame_done),
        .overrun_count      (overrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [17:0] ch0;
        logic [17:0] ch1;
        logic        ready;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   half = 3;   // bclk half period in clk cycles

`ifdef I2S_RX_OVERRUN_CNT_EN
    localparam int EXP_OVR = 3;
`else
    localparam int EXP_OVR = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int addr, input logic [17:0] l, input logic [17:0] r,
                        input logic rdy);
        exp_t e;
        e.addr = addr; e.ch0 = l; e.ch1 = r; e.ready = rdy;
        sb.push_back(e);
    endtask

    // Kept word for an n-bit slot value: top 18 bits, or left-justified with zero pad.
    function automatic logic [17:0] w18(input logic [31:0] val, input int n);
        logic [31:0] t;
        t = val << (32 - n);
        return t[31:14];
    endfunction

    // Called at a clk negedge; data changes with bclk falling, held for a whole bclk period.
    task automatic send_bit(input logic w, input logic d);
        i2s_bclk = 1'b0;
        i2s_ws   = w;
        i2s_din  = d;
        repeat (half) @(negedge clk);
        i2s_bclk = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    // ws flips on the slot's last bit (one-bit delay framing).
    task automatic send_slot(input logic ch, input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit((i == n - 1) ? ~ch : ch, val[n - 1 - i]);
        end
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int n);
        send_slot(1'b0, l, n);
        send_slot(1'b1, r, n);
    endtask

    // A short right slot ending in a 1->0 flip: the alignment point for capture.
    task automatic preamble();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
    endtask

    task automatic restart_enable();
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && pcm_write_enable) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", int'(pcm_write_addr), e.addr);
                chk("wr_ch0", int'(pcm_write_data_ch0), int'(e.ch0));
                chk("wr_ch1", int'(pcm_write_data_ch1), int'(e.ch1));
                chk("wr_frame_ready", int'(frame_ready), int'(e.ready));
            end
        end else if (rst_n && frame_ready) begin
            chk("frame_ready_without_write", 1, 0);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, int'(pcm_write_enable), 0);
        chk({tag, "_addr"}, int'(pcm_write_addr), 0);
        chk({tag, "_ch0"}, int'(pcm_write_data_ch0), 0);
        chk({tag, "_ch1"}, int'(pcm_write_data_ch1), 0);
        chk({tag, "_ready"}, int'(frame_ready), 0);
        chk({tag, "_overrun"}, int'(overrun_count), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b1;

        // 32-bit slots, junk beyond bit 18 must be ignored
        preamble();
        push(0, 18'h2ABCD, 18'h15555, 1'b0);
        send_pair(32'hAAF3_6A5A, 32'h5555_5234, 32);

        // 16-bit slots, LSBs zero-padded
        push(1, 18'h3FFFC, 18'h20004, 1'b0);
        send_pair(32'h0000_FFFF, 32'h0000_8001, 16);

        // enable raised in mid right slot
        repeat (10) @(negedge clk);
        enable = 1'b0;
        send_slot(1'b0, 32'h0000_7777, 16);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) enable = 1'b1;
            send_bit((i == 15) ? 1'b0 : 1'b1, 1'b1);
        end
        push(0, 18'h048D0, 18'h2AF34, 1'b0);
        send_pair(32'h0000_1234, 32'h0000_ABCD, 16);

        // Full buffer fill with 4-bit slots
        restart_enable();
        preamble();
        for (int i = 0; i < 576; i++) begin
            logic [31:0] lv;
            logic [31:0] rv;
            lv = 32'(i % 16);
            rv = 32'(15 - (i % 16));
            push(i, w18(lv, 4), w18(rv, 4), i == 575);
            send_pair(lv, rv, 4);
        end
        // Three dropped pairs while the consumer holds the buffer
        for (int i = 0; i < 3; i++) send_pair(32'h5, 32'hA, 4);
        repeat (10) @(negedge clk);
        chk("overrun_count", int'(overrun_count), EXP_OVR);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        push(0, 18'h24000, 18'h1C000, 1'b0);
        send_pair(32'h9, 32'h7, 4);
        push(1, 18'h3C3C3, 18'h0A5A5, 1'b0);
        send_pair({18'h3C3C3, 14'h0}, {18'h0A5A5, 14'h0}, 32);
        repeat (10) @(negedge clk);
        chk("overrun_after_release", int'(overrun_count), EXP_OVR);

        // Reset mid-way through the 10th bit of a left word
        for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b1);
        i2s_bclk = 1'b0;
        i2s_din  = 1'b1;
        repeat (half) @(negedge clk);
        i2s_bclk = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (half) @(negedge clk);
        for (int i = 10; i < 32; i++) send_bit((i == 31) ? 1'b1 : 1'b0, 1'b1);
        send_slot(1'b1, 32'hFFFF_FFFF, 32);
        push(0, 18'h12345, 18'h0F0F0, 1'b0);
        send_pair({18'h12345, 14'h0}, {18'h0F0F0, 14'h3FFF}, 32);

        // Same pairs at clk/6 and clk/40
        for (int s = 0; s < 2; s++) begin
            restart_enable();
            half = (s == 0) ? 3 : 20;
            preamble();
            push(0, 18'h30378, 18'h02EB4, 1'b0);
            push(1, 18'h16968, 18'h29694, 1'b0);
            send_pair(32'h0000_C0DE, 32'h0000_0BAD, 16);
            send_pair(32'h0000_5A5A, 32'h0000_A5A5, 16);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stage.md
# i2s_rx_stage

Serial-to-parallel I2S receiver. It is the capture-side counterpart of the I2S transmit stage. An external master drives `i2s_bclk` and `i2s_ws`. The block samples `i2s_din`, deserializes one left and one right word per frame, and writes each stereo pair into an external dual-channel PCM buffer. After a full granule of pairs it hands the buffer to the consumer with a ready/done handshake. Typical uses are loopback verification of the decoding chain and capture paths.

## Interface
- `SAMPLE_W`, 18: bits kept per channel word.
- `FRAME_LEN`, 576: stereo pairs per buffer fill.
- `ADDR_W`, 10: buffer address width; requires FRAME_LEN ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock (peripheral clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; capture allowed while high.
- `i2s_bclk`  in  1  asynchronous bit clock from the external master.
- `i2s_ws`  in  1  asynchronous word select; 0 = left/ch0, 1 = right/ch1.
- `i2s_din`  in  1  asynchronous serial data, MSB first.
- `pcm_write_enable`  out  1  one-cycle write strobe.
- `pcm_write_addr`  out  ADDR_W  pair index.
- `pcm_write_data_ch0`  out  SAMPLE_W  left word.
- `pcm_write_data_ch1`  out  SAMPLE_W  right word.
- `frame_ready`  out  1  one-cycle pulse when the buffer holds FRAME_LEN pairs.
- `frame_done`  in  1  one-cycle pulse from the consumer: buffer released.
- `overrun_count`  out  8  number of dropped pairs, saturating.

## Operation
**Synchronization and sampling**
- `i2s_bclk`, `i2s_ws` and `i2s_din` each pass through 2-FF synchronizers.
- A bit is sampled on each synchronized bclk rising edge, giving sample k = (ws_k, din_k).

**Framing (standard I2S, one-bit delay)**
- A slot change is ws_k ≠ ws_{k-1}.
- The sample at a slot-change edge k is the LSB position of the old slot.
- The samples at k+1 onward are the new slot, MSB first.

**Word assembly**
- The bit counter is cleared at each slot change.
- Bit n of the slot (n < SAMPLE_W) is stored at position SAMPLE_W-1-n.
- Bits with n ≥ SAMPLE_W are ignored.
- A slot shorter than SAMPLE_W is zero-padded in its LSBs.
- The word is finalized at the slot-change edge, with that edge's bit included.

**State machine** (reset state IDLE)
- IDLE:
  - Ignores bits.
  - On a ws 1→0 slot change while `enable` is high, goes to RUN. The left slot that starts there is the first captured word, so the first partial slot is discarded.
- RUN:
  - A finalized left word is latched into a hold register.
  - A finalized right word is written out together with the held left word.
  - The write address increments after each write.
  - The write with address FRAME_LEN-1 wraps the address to 0, pulses `frame_ready` in the same cycle, and moves to WAIT.
- WAIT:
  - Pairs are assembled but not written.
  - Each dropped pair increments `overrun_count`.
  - `frame_done` returns to RUN. The next write goes to address 0.
  - `frame_done` in any other state is ignored.
- `enable` low:
  - Returns to IDLE from any state at the next clk.
  - Resets the address to 0.
  - Discards the partial pair.
  - Leaves `overrun_count` unchanged.

**Simultaneous events**
- If `frame_done` arrives in the same cycle a right word finalizes in WAIT, the pair is dropped and counted; the state is RUN from the next cycle.

**Reset**
- Asynchronous. All outputs and registers go to 0 and the state goes to IDLE.
- A reset mid-word discards the word. Capture restarts at the next left-slot start.

## Timing
- A bclk rising edge at the pin is recognized 3 clk later: 2 synchronizer stages plus the edge register.
- `pcm_write_enable` is asserted 1 clk after the edge-detect cycle that finalizes a right word. Address and data are valid in the same cycle.
- `frame_ready` is coincident with the final write strobe of a fill.
- Requirements on bclk:
  - high and low phases each ≥ 3 clk periods;
  - ws and din stable for ≥ 2 clk around each rising bclk edge.
  Behaviour is undefined otherwise.
- The right word of each pair is captured before the write, so a new pair cannot overwrite data that has not yet been written.

## Configuration
- `I2S_RX_OVERRUN_CNT_EN` defined: `overrun_count` is the 8-bit saturating counter (it holds at 255) and is cleared only by reset.
- Not defined: `overrun_count` is tied to 0, no counter logic is generated, and drop behaviour is unchanged.

## Structure
- Package `i2s_pkg` holds:
  - the SAMPLE_W, FRAME_LEN and ADDR_W defaults;
  - the state encoding IDLE/RUN/WAIT;
  - the channel-select constants (LEFT = 0, RIGHT = 1).
- Sub-module `i2s_rx_sync`: three 2-FF synchronizers plus the bclk rising-edge detector. Its outputs are `bclk_rise`, `ws_s` and `din_s`.

## Test plan
- 32-bit slots, left 18'h2ABCD, right 18'h15555, after a valid 1→0 alignment edge → one write: addr 0, ch0 = 18'h2ABCD, ch1 = 18'h15555.
- 16-bit slots, left 16'hFFFF, right 16'h8001 → ch0 = 18'h3FFFC, ch1 = 18'h20004 (LSBs zero-padded).
- `enable` raised in mid right slot → the first write is for the following complete left/right pair, at addr 0.
- 576 pairs → 576 strobes at addr 0..575, a single `frame_ready` on the last one. Then 3 more pairs with no `frame_done` → no strobes, `overrun_count` = 3 (0 without the macro). Then `frame_done` → the next pair is written at addr 0.
- `rst_n` pulsed low mid-way through the 10th bit of a left word → all outputs 0 immediately. The next capture is written at addr 0 and contains only post-reset data.
- bclk at clk/6 versus clk/40 → identical write contents and order.
